wb_traffic_checker: RTL and testbench

Synthesizable, parametrised Wishbone B3 master traffic generator and checker, successor to the behavioural burst bench master. Issues a programmable number of write-burst/read-burst pairs with pseudo-random address, length, burst type and byte masks, then checks the read data on the fly. Needs no stored write data, because expected data is regenerated from a reseeded LFSR. Sits in place of the bench master in front of memory models and in FPGA self-test builds; adds byte masks, timeout, address window and burst truncation.

---
 rtl/wb_traffic_checker.sv | 199 +++++++++++++++++++
 tb/tb_wb_traffic_checker.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_traffic_checker.sv
// wb_traffic_checker: Wishbone B3 master generating LFSR write/read burst pairs and checking read-back data
module wb_traffic_checker #(
  parameter int aw = 32,
  parameter int dw = 32,
  parameter logic [aw-1:0] ADDR_BASE = '0,
  parameter logic [aw-1:0] ADDR_MASK = aw'(32'h0000_0FFF),
  parameter int MAX_BURST_LEN = 16,
  parameter int TIMEOUT = 1023,
  parameter logic [31:0] SEED = 32'h0000_0002
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            start_i,
  input  logic [15:0]     transactions_i,
  input  logic            sel_rand_i,
  output logic [aw-1:0]   wb_adr_o,
  output logic [dw-1:0]   wb_dat_o,
  output logic [dw/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [dw-1:0]   wb_sdt_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [1:0]      err_code_o,
  output logic [aw-1:0]   err_adr_o,
  output logic [15:0]     trans_cnt_o
);
  localparam int BPW = dw / 8;
  typedef enum logic [2:0] {IDLE, GEN, WRITE, GAP, READ, NEXT, DONE, FAIL} state_t;
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction
  function automatic logic [dw-1:0] rep(input logic [31:0] s);
    return dw'({(dw + 31) / 32{s}});
  endfunction
  function automatic logic [BPW-1:0] sel_of(input logic [31:0] s, input logic rnd);
    logic [63:0] ss;
    logic [BPW-1:0] m;
    ss = {s, s};
    m = ss[8 +: BPW];
    return (!rnd || m == '0) ? '1 : m;
  endfunction
  function automatic logic [dw-1:0] byte_en(input logic [BPW-1:0] s);
    logic [dw-1:0] m;
    for (int i = 0; i < BPW; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction
  // linear bursts pass b = all ones; wrap bursts keep the bits above the block fixed
  function automatic logic [aw-1:0] addr_of(input logic [aw-1:0] o, input logic [aw-1:0] b, input logic [8:0] i);
    return ADDR_BASE + (((o & ~b) | ((o + aw'(i) * aw'(BPW)) & b)) & ADDR_MASK);
  endfunction
  state_t        state;
  logic [31:0]   c, d, dseed, wait_cnt;
  logic [aw-1:0] off0, blk;
  logic [8:0]    len, k;
  logic [1:0]    bte_r;
  logic [15:0]   tgt;
  logic          sel_r;
  logic [31:0]   c1, c2, c3, g_dseed, nd;
  logic [aw-1:0] g_off, g_blk, lin_lim;
  logic [8:0]    g_raw, g_n, g_len;
  logic [1:0]    g_type, fail_code;
  logic          last, mism, fail_now;
  // burst parameters drawn from four consecutive control LFSR states, plus per-beat checks
  always_comb begin
    c1 = lfsr_step(c);
    c2 = lfsr_step(c1);
    c3 = lfsr_step(c2);
    g_off = aw'(c) & ADDR_MASK & ~aw'(BPW - 1);
    g_raw = 9'(c1 % 32'(MAX_BURST_LEN)) + 9'd1;
    g_type = c2[1:0];
    g_n = 9'd2 << g_type;
    lin_lim = (ADDR_MASK - g_off) / aw'(BPW) + aw'(1);
    g_len = g_type == 2'd0 ? (lin_lim < aw'(g_raw) ? 9'(lin_lim) : g_raw) : (g_raw > g_n ? g_n : g_raw);
    g_blk = g_type == 2'd0 ? '1 : aw'(g_n) * aw'(BPW) - aw'(1);
    g_dseed = c3 == '0 ? 32'd1 : c3;
    nd = lfsr_step(d);
    last = k == len - 9'd1;
    mism = |((wb_sdt_i ^ rep(d)) & byte_en(wb_sel_o));
    fail_now = wb_err_i | wb_rty_i | (wb_ack_i & state == READ & mism) | (!wb_ack_i & wait_cnt == 32'(TIMEOUT));
    fail_code = wb_err_i ? 2'd2 : wb_rty_i ? 2'd0 : wb_ack_i ? 2'd1 : 2'd3;
  end
  // run sequencer; every bus and status output is registered here
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      c <= SEED;
      d <= '0;
      dseed <= '0;
      wait_cnt <= '0;
      off0 <= '0;
      blk <= '0;
      len <= '0;
      k <= '0;
      bte_r <= '0;
      tgt <= '0;
      sel_r <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_cti_o <= '0;
      wb_bte_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      err_code_o <= '0;
      err_adr_o <= '0;
      trans_cnt_o <= '0;
    end else begin
      case (state)
        IDLE, DONE, FAIL: if (start_i) begin
          state <= transactions_i == '0 ? DONE : GEN;
          done_o <= transactions_i == '0;
          busy_o <= transactions_i != '0;
          err_o <= 1'b0;
          err_code_o <= '0;
          err_adr_o <= '0;
          trans_cnt_o <= '0;
          tgt <= transactions_i;
          sel_r <= sel_rand_i;
        end
        GEN: begin
          state <= WRITE;
          c <= lfsr_step(c3);
          off0 <= g_off;
          blk <= g_blk;
          len <= g_len;
          bte_r <= g_len == 9'd1 ? 2'd0 : g_type;
          dseed <= g_dseed;
          d <= g_dseed;
          k <= '0;
          wait_cnt <= '0;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o <= 1'b1;
          wb_adr_o <= addr_of(g_off, g_blk, 9'd0);
          wb_dat_o <= rep(g_dseed);
          wb_sel_o <= sel_of(g_dseed, sel_r);
          wb_cti_o <= g_len == 9'd1 ? 3'b111 : 3'b010;
          wb_bte_o <= g_len == 9'd1 ? 2'd0 : g_type;
        end
        WRITE, READ: if (fail_now) begin
          state <= FAIL;
          err_o <= 1'b1;
          err_code_o <= fail_code;
          err_adr_o <= wb_adr_o;
          busy_o <= 1'b0;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
        end else if (wb_ack_i && last) begin
          state <= state == WRITE ? GAP : NEXT;
          d <= dseed;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
        end else if (wb_ack_i) begin
          k <= k + 9'd1;
          d <= nd;
          wait_cnt <= '0;
          wb_adr_o <= addr_of(off0, blk, k + 9'd1);
          wb_dat_o <= rep(nd);
          wb_sel_o <= sel_of(nd, sel_r);
          wb_cti_o <= k + 9'd2 == len ? 3'b111 : 3'b010;
        end else begin
          wait_cnt <= wait_cnt + 32'd1;
        end
        GAP: begin
          state <= READ;
          k <= '0;
          wait_cnt <= '0;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o <= 1'b0;
          wb_adr_o <= addr_of(off0, blk, 9'd0);
          wb_dat_o <= rep(d);
          wb_sel_o <= sel_of(d, sel_r);
          wb_cti_o <= len == 9'd1 ? 3'b111 : 3'b010;
          wb_bte_o <= bte_r;
        end
        NEXT: begin
          trans_cnt_o <= trans_cnt_o + 16'd1;
          state <= trans_cnt_o + 16'd1 == tgt ? DONE : GEN;
          done_o <= trans_cnt_o + 16'd1 == tgt;
          busy_o <= trans_cnt_o + 16'd1 != tgt;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_traffic_checker.sv
// tb_wb_traffic_checker: scoreboard bench with a memory slave and a burst-level reference model
module tb_wb_traffic_checker;
  localparam int TO = 15;
  localparam logic [31:0] SEED = 32'h0000_0002;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, selr = 1'b0;
  logic [15:0] ntr = '0;
  logic [31:0] adr, dat, sdt = '0, eadr;
  logic [3:0] sel;
  logic we, cyc, stb, ack = 1'b0, err = 1'b0, rty = 1'b0, busy, done, errf;
  logic [2:0] cti;
  logic [1:0] bte, code;
  logic [15:0] tcnt;
  wb_traffic_checker #(.TIMEOUT(TO), .SEED(SEED)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .transactions_i(ntr), .sel_rand_i(selr),
    .wb_adr_o(adr), .wb_dat_o(dat), .wb_sel_o(sel), .wb_we_o(we), .wb_cyc_o(cyc), .wb_stb_o(stb),
    .wb_cti_o(cti), .wb_bte_o(bte), .wb_sdt_i(sdt), .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty),
    .busy_o(busy), .done_o(done), .err_o(errf), .err_code_o(code), .err_adr_o(eadr), .trans_cnt_o(tcnt));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] adr;
    logic we;
    logic [3:0] sel;
    logic [2:0] cti;
    logic [1:0] bte;
    logic [31:0] dat;
    int tx;
  } beat_t;
  beat_t exp_q[$];
  int tests = 0, fails = 0, cnt = 0, last_ack_cnt = -10;
  int mode = 0, maxw = 0, err_beat = 0, beat_no = 0, wleft = 0;
  logic [31:0] mc, flip_adr = '0;
  logic [31:0] mem [0:1023];
  bit flip_en = 0, desync = 0, nb = 1;
  function automatic logic [31:0] lstep(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask
  // expected beats of n write/read pairs, built from burst rules with plain arithmetic
  task automatic model(input int n, input bit sr);
    logic [31:0] c0, c1, c2, c3, ds, d, off, base;
    int len, typ, nbk, maxb;
    beat_t e;
    for (int t = 0; t < n; t++) begin
      c0 = mc; c1 = lstep(c0); c2 = lstep(c1); c3 = lstep(c2); mc = lstep(c3);
      off = c0 & 32'h0000_0FFC;
      len = int'(c1 % 32'd16) + 1;
      typ = int'(c2 & 32'd3);
      ds = c3 == 0 ? 32'd1 : c3;
      nbk = 2 << typ;
      if (typ == 0) begin
        maxb = int'((32'hFFF - off) / 32'd4) + 1;
        if (len > maxb) len = maxb;
      end else if (len > nbk) len = nbk;
      base = off - off % 32'(4 * nbk);
      for (int w = 1; w >= 0; w--) begin
        d = ds;
        for (int k = 0; k < len; k++) begin
          e.adr = typ == 0 ? off + 32'(4 * k) : base + (off - base + 32'(4 * k)) % 32'(4 * nbk);
          e.we = w == 1;
          e.sel = !sr ? 4'hF : (d[11:8] == 4'h0 ? 4'hF : d[11:8]);
          e.cti = k == len - 1 ? 3'b111 : 3'b010;
          e.bte = len == 1 ? 2'd0 : 2'(typ);
          e.dat = d;
          e.tx = t;
          exp_q.push_back(e);
          d = lstep(d);
        end
      end
    end
  endtask
  always @(posedge clk) cnt++;
  // memory slave: random wait states, optional err/rty/stall/bit-flip faults
  always @(negedge clk) begin
    ack = 1'b0; err = 1'b0; rty = 1'b0;
    if (cyc && stb) begin
      if (nb) begin
        wleft = maxw > 0 ? int'($urandom_range(0, maxw)) : 0;
        nb = 0;
      end
      if (mode != 1) begin
        if (wleft > 0) wleft--;
        else begin
          beat_no++;
          nb = 1;
          if (mode == 3) rty = 1'b1;
          else if (mode == 2 && beat_no == err_beat) begin
            err = 1'b1;
            ack = 1'b1;
          end else begin
            ack = 1'b1;
            if (we) begin
              for (int b = 0; b < 4; b++) if (sel[b]) mem[adr[11:2]][b*8 +: 8] = dat[b*8 +: 8];
            end else sdt = mem[adr[11:2]] ^ {31'd0, flip_en && adr == flip_adr};
          end
        end
      end
    end else nb = 1;
  end
  // monitor: every completed beat is checked against the next expected beat
  always @(negedge clk) begin
    beat_t e;
    #1;
    if (cyc && stb && ack && !err && !rty) begin
      last_ack_cnt = cnt;
      if (!desync) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          desync = 1;
          $display("FAIL beat_extra got adr=%h we=%b, none expected", adr, we);
        end else begin
          e = exp_q.pop_front();
          if (adr !== e.adr || we !== e.we || sel !== e.sel || cti !== e.cti || bte !== e.bte || (e.we && dat !== e.dat)) begin
            fails++;
            desync = 1;
            $display("FAIL beat tx%0d got adr=%h we=%b sel=%h cti=%b bte=%b dat=%h want adr=%h we=%b sel=%h cti=%b bte=%b dat=%h",
                     e.tx, adr, we, sel, cti, bte, dat, e.adr, e.we, e.sel, e.cti, e.bte, e.dat);
          end
        end
      end
    end
  end
  task automatic do_start(input int n, input bit sr);
    @(negedge clk);
    ntr = 16'(n);
    selr = sr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mc = SEED;
    exp_q.delete();
    desync = 0;
    beat_no = 0;
  endtask
  task automatic wait_end(input int budget);
    int i = 0;
    while (!(done || errf) && i < budget) begin
      @(negedge clk);
      #2;
      i++;
    end
    tests++;
    if (!(done || errf)) begin
      fails++;
      $display("FAIL run_end got no done/err within %0d cycles", budget);
    end
  endtask
  initial begin
    beat_t e;
    int n, ftx;
    bit found;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_bus", {adr, dat, sel, we, cyc, stb, cti, bte}, '0);
    chk("rst_status", {busy, done, errf, code, eadr, tcnt}, '0);
    @(negedge clk);
    rst = 1'b0;
    mc = SEED;
    model(1000, 0);
    do_start(1000, 0);
    chk("busy_after_start", busy, 1);
    wait_end(40000);
    chk("runA_status", {done, errf, tcnt}, {1'b1, 1'b0, 16'd1000});
    chk("runA_left", exp_q.size(), 0);
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_BEEF;
    maxw = 2;
    model(500, 1);
    do_start(500, 1);
    wait_end(40000);
    chk("runB_status", {done, errf, tcnt}, {1'b1, 1'b0, 16'd500});
    chk("runB_left", exp_q.size(), 0);
    maxw = 0;
    do_start(0, 0);
    chk("zero_tx", {done, errf, busy, tcnt}, {1'b1, 1'b0, 1'b0, 16'd0});
    do_reset();
    model(1000, 0);
    found = 0;
    foreach (exp_q[i]) if (!found && !exp_q[i].we && exp_q[i].adr == 32'h100) found = 1;
    flip_adr = 32'h100;
    if (!found) foreach (exp_q[i]) if (!found && !exp_q[i].we && exp_q[i].tx == 2) begin
      flip_adr = exp_q[i].adr;
      found = 1;
    end
    found = 0;
    ftx = 0;
    foreach (exp_q[i]) if (!found && !exp_q[i].we && exp_q[i].adr == flip_adr) begin
      ftx = exp_q[i].tx;
      found = 1;
    end
    flip_en = 1;
    do_start(1000, 0);
    wait_end(40000);
    chk("mism_status", {errf, done, code, eadr, tcnt}, {1'b1, 1'b0, 2'd1, flip_adr, 16'(ftx)});
    chk("mism_cyc_next", {cyc, stb, 32'(cnt - last_ack_cnt)}, {1'b0, 1'b0, 32'd1});
    flip_en = 0;
    do_reset();
    model(50, 0);
    e = exp_q[2];
    mode = 2;
    err_beat = 3;
    do_start(50, 0);
    wait_end(2000);
    chk("buserr_status", {errf, code, eadr, tcnt}, {1'b1, 2'd2, e.adr, 16'(e.tx)});
    mode = 0;
    do_reset();
    model(1, 0);
    e = exp_q[0];
    mode = 1;
    do_start(1, 0);
    n = 0;
    for (int i = 0; i < 100 && !errf; i++) begin
      @(negedge clk);
      #2;
      if (cyc && stb) n++;
    end
    chk("timeout_cycles", n, TO + 1);
    chk("timeout_status", {errf, code, eadr, cyc}, {1'b1, 2'd3, e.adr, 1'b0});
    mode = 0;
    do_reset();
    model(1, 0);
    e = exp_q[0];
    mode = 3;
    do_start(1, 0);
    wait_end(100);
    chk("rty_status", {errf, done, code, eadr}, {1'b1, 1'b0, 2'd0, e.adr});
    mode = 0;
    do_reset();
    model(20, 0);
    do_start(20, 0);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      #2;
      found = beat_no >= 2 && cyc && stb && we;
    end
    chk("mid_burst_found", found, 1);
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("midrst_bus", {adr, dat, sel, we, cyc, stb, cti, bte}, '0);
    chk("midrst_status", {busy, done, errf, code, eadr, tcnt}, '0);
    rst = 1'b0;
    mc = SEED;
    exp_q.delete();
    desync = 0;
    model(5, 0);
    do_start(5, 0);
    wait_end(2000);
    chk("restart_status", {done, errf, tcnt}, {1'b1, 1'b0, 16'd5});
    chk("restart_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
